// File: rtl/simple_div.sv
// Unsigned restoring divider: one quotient bit per cycle over XLEN cycles.
// Optional SIMPLE_DIV_DBZ_CHECK_EN short-circuits divide-by-zero straight to DONE.
module simple_div #(
  parameter int unsigned XLEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned RW = XLEN + 1;
  localparam int unsigned SW = XLEN + 2;
  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e            state_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   dvd_q;
  logic [XLEN-1:0]   dvs_q;
  logic [RW-1:0]     rem_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN-1:0]   remo_q;

  logic [SW-1:0]     rem_shift;
  logic [SW-1:0]     rem_diff;
  logic              q_bit;
  logic [RW-1:0]     rem_d;
  logic [XLEN-1:0]   dvd_d;
  logic [CW-1:0]     cnt_d;
  logic              last_iter;

  // One restoring step: shift {rem, dividend} left, trial-subtract the divisor.
  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    rem_diff  = rem_shift - SW'(dvs_q);
    q_bit     = (rem_shift >= SW'(dvs_q));
    rem_d     = q_bit ? RW'(rem_diff) : RW'(rem_shift);
    dvd_d     = XLEN'({dvd_q, q_bit});
    cnt_d     = cnt_q + CW'(1);
    last_iter = (cnt_q == CW'(XLEN - 1));
  end

`ifdef SIMPLE_DIV_DBZ_CHECK_EN
  logic dbz_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
`ifdef SIMPLE_DIV_DBZ_CHECK_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= a;
            dvs_q <= b;
            rem_q <= '0;
            cnt_q <= '0;
`ifdef SIMPLE_DIV_DBZ_CHECK_EN
            if (b == '0) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              quot_q  <= '1;
              remo_q  <= a;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= OPERATE;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
`else
            state_q <= OPERATE;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`endif
          end
        end
        OPERATE: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_d;
          // Results are captured only on the final step, so they hold between operations.
          if (last_iter) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= dvd_d;
            remo_q  <= XLEN'(rem_d);
`ifdef SIMPLE_DIV_DBZ_CHECK_EN
            dbz_q   <= 1'b0;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
`ifdef SIMPLE_DIV_DBZ_CHECK_EN
  assign dbz       = dbz_q;
`else
  assign dbz       = 1'b0;
`endif

endmodule
